// File: rtl/flag_branch_unit.sv
// flag_branch_unit
// Architectural {N,Z,V} flag register fed by the EX-stage ALU, with per-opcode
// field write masks, plus branch condition evaluation for the branch in ID.
// When BYPASS is set, the branch sees the fields about to be written by a
// qualifying flag-setter in EX, so no stall is needed for the flag hazard.
module flag_branch_unit #(
   parameter bit         BYPASS    = 1'b1,
   parameter logic [2:0] RST_FLAGS = 3'b000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ex_valid,
   input  logic       ex_is_alu,
   input  logic [2:0] ex_alu_op,
   input  logic [2:0] ex_flags,
   input  logic       stall,
   input  logic       flush,
   input  logic       id_is_br,
   input  logic [2:0] id_cond,
   output logic [2:0] flags_q,
   output logic       br_taken,
   output logic       flag_wr
);

   typedef enum logic [2:0] {
      OP_ADD    = 3'b000,
      OP_SUB    = 3'b001,
      OP_XOR    = 3'b010,
      OP_RED    = 3'b011,
      OP_SLL    = 3'b100,
      OP_SRA    = 3'b101,
      OP_ROR    = 3'b110,
      OP_PADDSB = 3'b111
   } alu_op_e;

   typedef enum logic [2:0] {
      CC_NE  = 3'b000,
      CC_EQ  = 3'b001,
      CC_GT  = 3'b010,
      CC_LT  = 3'b011,
      CC_GE  = 3'b100,
      CC_LE  = 3'b101,
      CC_OV  = 3'b110,
      CC_UNC = 3'b111
   } cond_e;

   // Field positions inside {N,Z,V}
   localparam int unsigned FN = 2;
   localparam int unsigned FZ = 1;
   localparam int unsigned FV = 0;

   logic       upd;
   logic [2:0] op_mask;
   logic [2:0] wr_mask;
   logic [2:0] flags_d;
   logic [2:0] eff_flags;

   // Only a live, advancing, unsquashed ALU instruction may touch the flags;
   // ex_valid gates everything else so a bubble's inputs never matter.
   assign upd = ex_valid & ex_is_alu & ~stall & ~flush;

   // Decode which flag fields the EX opcode owns
   always_comb begin
      op_mask = '0;
      case (alu_op_e'(ex_alu_op))
         OP_ADD, OP_SUB:                 op_mask = 3'b111;
         OP_XOR, OP_SLL, OP_SRA, OP_ROR: op_mask = 3'b010;
         default:                        op_mask = '0;
      endcase
   end

   // The mask is forced to zero when not updating so X on ignored inputs
   // cannot leak into the merge below.
   assign wr_mask = upd ? op_mask : '0;
   assign flag_wr = |wr_mask;

   // Per-field merge of new ALU flags into the held register value
   always_comb begin
      flags_d = (ex_flags & wr_mask) | (flags_q & ~wr_mask);
   end

   // Flag register, asynchronously returned to its reset value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= RST_FLAGS;
      end else begin
         flags_q <= flags_d;
      end
   end

   // Branch sees next-state flags when bypassing; flags_d equals flags_q
   // whenever no update is pending, so stall/flush suppress the bypass too.
   always_comb begin
      eff_flags = BYPASS ? flags_d : flags_q;
   end

   // Condition code evaluation against the effective flags
   always_comb begin
      br_taken = 1'b0;
      if (id_is_br) begin
         case (cond_e'(id_cond))
            CC_NE:   br_taken = ~eff_flags[FZ];
            CC_EQ:   br_taken =  eff_flags[FZ];
            CC_GT:   br_taken = ~eff_flags[FZ] & ~eff_flags[FN];
            CC_LT:   br_taken =  eff_flags[FN];
            CC_GE:   br_taken =  eff_flags[FZ] | (~eff_flags[FZ] & ~eff_flags[FN]);
            CC_LE:   br_taken =  eff_flags[FN] | eff_flags[FZ];
            CC_OV:   br_taken =  eff_flags[FV];
            CC_UNC:  br_taken = 1'b1;
            default: br_taken = 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed testbench for flag_branch_unit: a bypassing instance and a
// non-bypassing instance share all inputs; expectations are hand-computed.
`timescale 1ns/1ps
module tb_flag_branch_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ex_valid, ex_is_alu, stall, flush, id_is_br;
   logic [2:0] ex_alu_op, ex_flags, id_cond;
   logic [2:0] flags_b, flags_n;
   logic       br_b, br_n, wr_b, wr_n;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   flag_branch_unit #(.BYPASS(1'b1), .RST_FLAGS(3'b000)) u_byp (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_alu(ex_is_alu),
      .ex_alu_op(ex_alu_op), .ex_flags(ex_flags), .stall(stall), .flush(flush),
      .id_is_br(id_is_br), .id_cond(id_cond),
      .flags_q(flags_b), .br_taken(br_b), .flag_wr(wr_b)
   );

   flag_branch_unit #(.BYPASS(1'b0), .RST_FLAGS(3'b000)) u_nobyp (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_is_alu(ex_is_alu),
      .ex_alu_op(ex_alu_op), .ex_flags(ex_flags), .stall(stall), .flush(flush),
      .id_is_br(id_is_br), .id_cond(id_cond),
      .flags_q(flags_n), .br_taken(br_n), .flag_wr(wr_n)
   );

   task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive_ex(input logic v, input logic alu, input logic [2:0] op,
                           input logic [2:0] f, input logic st, input logic fl);
      ex_valid  = v;
      ex_is_alu = alu;
      ex_alu_op = op;
      ex_flags  = f;
      stall     = st;
      flush     = fl;
   endtask

   task automatic drive_br(input logic b, input logic [2:0] c);
      id_is_br = b;
      id_cond  = c;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp_cc;
      rst_n = 1'b0;
      drive_ex(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      drive_br(1'b0, 3'b000);
      #12;
      check_eq("reset_flags", {5'd0, flags_b}, 8'h00);
      rst_n = 1'b1;
      #2;

      // Load 111 then reset mid-cycle
      drive_ex(1'b1, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0);
      tick();
      check_eq("pre_reset_flags", {5'd0, flags_b}, 8'h07);
      #2 rst_n = 1'b0;
      #1 check_eq("async_reset", {5'd0, flags_b}, 8'h00);
      check_eq("async_reset_nb", {5'd0, flags_n}, 8'h00);
      // pending ADD 111 must not complete while reset is held
      tick();
      check_eq("reset_no_write", {5'd0, flags_b}, 8'h00);
      drive_ex(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      // flags 000: NE,GT,GE,UNC taken
      exp_cc = 8'b1001_0101;
      for (int c = 0; c < 8; c++) begin
         drive_br(1'b1, c[2:0]);
         #1 check_eq($sformatf("reset_cc%0d", c), {7'd0, br_b}, {7'd0, exp_cc[c]});
      end
      drive_br(1'b0, 3'b111);
      #1 check_eq("no_branch", {7'd0, br_b}, 8'h00);
      #1 rst_n = 1'b1;

      // SUB 5-5
      drive_ex(1'b1, 1'b1, 3'b001, 3'b010, 1'b0, 1'b0);
      #1 check_eq("sub_flag_wr", {7'd0, wr_b}, 8'h01);
      tick();
      check_eq("sub_flags", {5'd0, flags_b}, 8'h02);
      drive_ex(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      drive_br(1'b1, 3'b001);
      #1 check_eq("eq_taken", {7'd0, br_b}, 8'h01);
      drive_br(1'b1, 3'b000);
      #1 check_eq("ne_not_taken", {7'd0, br_b}, 8'h00);
      drive_br(1'b0, 3'b000);

      // Selective update
      drive_ex(1'b1, 1'b1, 3'b000, 3'b101, 1'b0, 1'b0);
      tick();
      check_eq("add_flags", {5'd0, flags_b}, 8'h05);
      drive_ex(1'b1, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0);
      tick();
      check_eq("xor_z_only", {5'd0, flags_b}, 8'h07);
      drive_ex(1'b1, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0);
      #1 check_eq("paddsb_no_wr", {7'd0, wr_b}, 8'h00);
      tick();
      check_eq("paddsb_hold", {5'd0, flags_b}, 8'h07);
      drive_ex(1'b1, 1'b1, 3'b011, 3'b000, 1'b0, 1'b0);
      tick();
      check_eq("red_hold", {5'd0, flags_b}, 8'h07);
      drive_ex(1'b1, 1'b1, 3'b100, 3'b000, 1'b0, 1'b0);
      tick();
      check_eq("sll_clear_z", {5'd0, flags_b}, 8'h05);

      // Back-to-back: ADD 110 then XOR 000 -> N,V from ADD, Z from XOR
      drive_ex(1'b1, 1'b1, 3'b000, 3'b110, 1'b0, 1'b0);
      tick();
      drive_ex(1'b1, 1'b1, 3'b010, 3'b000, 1'b0, 1'b0);
      tick();
      check_eq("b2b_flags", {5'd0, flags_b}, 8'h04);

      // Bypass
      drive_ex(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
      tick();
      check_eq("clear_flags", {5'd0, flags_b}, 8'h00);
      drive_ex(1'b1, 1'b1, 3'b000, 3'b100, 1'b0, 1'b0);
      drive_br(1'b1, 3'b011);
      #1 check_eq("bypass_lt", {7'd0, br_b}, 8'h01);
      check_eq("nobypass_lt", {7'd0, br_n}, 8'h00);
      drive_ex(1'b1, 1'b1, 3'b000, 3'b100, 1'b1, 1'b0);
      #1 check_eq("stall_no_bypass", {7'd0, br_b}, 8'h00);
      drive_ex(1'b1, 1'b1, 3'b000, 3'b100, 1'b0, 1'b1);
      #1 check_eq("flush_no_bypass", {7'd0, br_b}, 8'h00);
      // XOR owns Z only: N=1,V=1 in ex_flags must not bypass
      drive_ex(1'b1, 1'b1, 3'b010, 3'b101, 1'b0, 1'b0);
      #1 check_eq("xor_byp_lt", {7'd0, br_b}, 8'h00);
      drive_br(1'b1, 3'b110);
      #1 check_eq("xor_byp_ov", {7'd0, br_b}, 8'h00);
      drive_ex(1'b1, 1'b1, 3'b010, 3'b010, 1'b0, 1'b0);
      drive_br(1'b1, 3'b001);
      #1 check_eq("xor_byp_eq", {7'd0, br_b}, 8'h01);
      check_eq("xor_nobyp_eq", {7'd0, br_n}, 8'h00);
      drive_ex(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);

      // Flush / stall
      drive_ex(1'b1, 1'b1, 3'b001, 3'b001, 1'b0, 1'b1);
      drive_br(1'b1, 3'b110);
      #1 check_eq("flush_wr", {7'd0, wr_b}, 8'h00);
      check_eq("flush_ov", {7'd0, br_b}, 8'h00);
      tick();
      check_eq("flush_hold", {5'd0, flags_b}, 8'h00);
      drive_ex(1'b1, 1'b1, 3'b001, 3'b001, 1'b1, 1'b1);
      tick();
      check_eq("flush_stall_hold", {5'd0, flags_b}, 8'h00);
      drive_ex(1'b1, 1'b1, 3'b001, 3'b001, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("stall_wr%0d", i), {7'd0, wr_b}, 8'h00);
         tick();
         check_eq($sformatf("stall_hold%0d", i), {5'd0, flags_b}, 8'h00);
      end
      drive_ex(1'b1, 1'b1, 3'b001, 3'b001, 1'b0, 1'b0);
      #1 check_eq("release_wr", {7'd0, wr_b}, 8'h01);
      check_eq("release_byp_ov", {7'd0, br_b}, 8'h01);
      check_eq("release_nobyp_ov", {7'd0, br_n}, 8'h00);
      tick();
      check_eq("release_flags", {5'd0, flags_b}, 8'h01);
      drive_ex(1'b0, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
      #1 check_eq("ov_reg_nobyp", {7'd0, br_n}, 8'h01);

      // Non-ALU add
      drive_ex(1'b1, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
      #1 check_eq("nonalu_wr", {7'd0, wr_b}, 8'h00);
      tick();
      check_eq("nonalu_hold", {5'd0, flags_b}, 8'h01);

      // Bubble with unknown payload
      drive_ex(1'b0, 1'bx, 3'bxxx, 3'bxxx, 1'b0, 1'b0);
      #1 check_eq("bubble_wr", {7'd0, wr_b}, 8'h00);
      tick();
      check_eq("bubble_hold", {5'd0, flags_b}, 8'h01);
      check_eq("bubble_hold_nb", {5'd0, flags_n}, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
